drive_pause_sequencer: RTL and testbench
========================================

Name: drive_pause_sequencer

Overview:
Central stop/resume controller for the drive train.
- Collects stop requests from several obstacle/fault sensors and applies a per-source mask.
- Reports the winning source.
- Sequences the motor enable through a timed full stop, then a timed creep (soft-resume) phase, then back to run.
- Sits between the sensor front-ends and the motor PWM/H-bridge enable logic. Its pause output tells the path planner to hold new motion commands.

Parameters:
- NUM_SRC, 4: number of stop-request sources, 2..8.
- STOP_CYC, 75_000_000: minimum full-stop duration in clk cycles, counted after the last active request (0.75 s at 100 MHz).
- RESUME_CYC, 75_000_000: creep-phase duration in clk cycles.
- CNT_W, 28: phase timer width. Must satisfy 2^CNT_W > max(STOP_CYC, RESUME_CYC).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- stop_req, input, NUM_SRC: level stop requests; asynchronous to clk.
- src_mask, input, NUM_SRC: 1 = source enabled. Synchronous to clk.
- manual_clear, input, 1: single-cycle operator release pulse. Used only when DRIVE_PAUSE_LATCH_EN is defined.
- enable, output, 1: motor drive enable, registered.
- pause, output, 1: motion hold to planner, registered.
- cause, output, $clog2(NUM_SRC): index of the source that caused the most recent stop.
- cause_valid, output, 1: cause holds a real source index.
- stop_count, output, 8: number of RUN/CREEP→STOP entries, saturating.

Behaviour:
- Clock and reset: one clock domain (clk). rst_n is asynchronous assert, synchronous deassert handled upstream.
- Reset values: state=STOP, timer=0, enable=0, pause=1, cause=0, cause_valid=0, stop_count=0. The drive therefore stays stopped for STOP_CYC cycles after reset.
- Input conditioning:
  - stop_req passes through a 2-flop synchronizer per bit.
  - act = sync_req & src_mask.
  - any_act = |act.
- Priority: the lowest set index of act wins and is written to cause.
- Latency: stop_req rising to enable falling is 3 clk cycles (2 sync + 1 registered state/output).
- States:
  - STOP: enable=0, pause=1.
  - CREEP: enable=1, pause=1.
  - RUN: enable=1, pause=0.
  - Outputs are a registered decode of the next state, so they change in the same cycle as the state register.
- RUN:
  - If any_act: go to STOP, timer←0, cause←winner, cause_valid←1, stop_count←stop_count+1.
  - stop_count saturates at 255.
- STOP:
  - If any_act: timer←0 and remain in STOP. cause is not updated (the first cause is kept).
  - Else if timer==STOP_CYC-1: go to CREEP, timer←0.
  - Else: timer←timer+1.
  - Minimum stop time after the last request drops is exactly STOP_CYC cycles.
- CREEP:
  - If any_act: go to STOP, timer←0, cause←winner, stop_count increments (saturating).
  - Else if timer==RESUME_CYC-1: go to RUN, timer←0.
  - Else: timer←timer+1.
- Mask changes:
  - Masking an active source removes it from any_act on the next cycle.
  - Masking never forces a state change by itself.
- Simultaneous requests: several bits rising in the same cycle produce a single stop_count increment. cause takes the lowest index.
- Timer: unsigned CNT_W bits. It never wraps, because it is reset at each terminal count.
- Reset mid-phase: state returns asynchronously to STOP with timer=0. stop_count and cause are cleared.

Optional Feature:
- Macro: DRIVE_PAUSE_LATCH_EN.
- Defined:
  - STOP does not auto-advance. When timer reaches STOP_CYC-1 with no active request, timer holds.
  - The block leaves STOP for CREEP only on a manual_clear pulse, and only if any_act==0 and the timer is done.
  - manual_clear at any other time is ignored.
- Undefined: manual_clear is ignored entirely and behaviour is as above.

Decomposition:
- Package drive_pkg holds:
  - the state encoding: ST_STOP=2'd0, ST_CREEP=2'd1, ST_RUN=2'd2;
  - default timing constants STOP_CYC_DEF and RESUME_CYC_DEF;
  - the stop_count width (8).
- One sub-module, sync_2ff: a parameterized-width two-flop synchronizer with async active-low reset, instanced once for stop_req.
- Priority encoder and FSM stay inline.

Test Plan:
All scenarios use NUM_SRC=4, STOP_CYC=8, RESUME_CYC=4, src_mask=4'hF.
- Reset release, no requests:
  - enable=0 and pause=1 for 8 cycles.
  - CREEP (enable=1, pause=1) for 4 cycles.
  - Then RUN (enable=1, pause=0).
  - stop_count=0, cause_valid=0.
- In RUN, stop_req=4'b0100 for 1 cycle:
  - enable falls exactly 3 cycles later.
  - cause=2, cause_valid=1, stop_count=1.
  - RUN is re-entered 8+4 cycles after the synced request drops.
- stop_req=4'b1010 asserted together in RUN: cause=1, stop_count increments by exactly 1.
- Request held 20 cycles in STOP: enable stays 0 throughout. STOP lasts 8 cycles after the release is synced. cause is unchanged.
- Request on bit 3 during CREEP cycle 2:
  - return to STOP; cause=3; stop_count increments;
  - full 8-cycle STOP then 4-cycle CREEP follow.
- src_mask=4'b1110 with stop_req=4'b0001: no state change, stop_count unchanged.
- With DRIVE_PAUSE_LATCH_EN:
  - STOP holds past 8 cycles.
  - manual_clear while a request is active is ignored.
  - manual_clear after the request drops and the timer is done moves to CREEP on the next cycle.

Source files
------------

// File: rtl/drive_pkg.sv
// Shared encodings and default timing for the drive pause sequencer.
package drive_pkg;

    // Sequencer phase encoding
    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_CREEP = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    // Default phase lengths: 0.75 s each at 100 MHz
    localparam int unsigned STOP_CYC_DEF   = 75_000_000;
    localparam int unsigned RESUME_CYC_DEF = 75_000_000;
    localparam int unsigned CNT_W_DEF      = 28;

    // Width of the saturating stop-event counter
    localparam int unsigned STOP_CNT_W = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent level signals.
module sync_2ff #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Two-stage capture of asynchronous levels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/drive_pause_sequencer.sv
// Drive-train stop/resume sequencer: masked stop requests force a timed full
// stop, followed by a timed creep phase before returning to normal run.
// Optional macro DRIVE_PAUSE_LATCH_EN: the stop phase is held after its timer
// expires until an operator manual_clear pulse releases it.
module drive_pause_sequencer
    import drive_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned STOP_CYC   = STOP_CYC_DEF,
    parameter int unsigned RESUME_CYC = RESUME_CYC_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           stop_req,
    input  logic [NUM_SRC-1:0]           src_mask,
    input  logic                         manual_clear,
    output logic                         enable,
    output logic                         pause,
    output logic [$clog2(NUM_SRC)-1:0]   cause,
    output logic                         cause_valid,
    output logic [STOP_CNT_W-1:0]        stop_count
);

    localparam int unsigned CAUSE_W = $clog2(NUM_SRC);
    localparam logic [CNT_W-1:0] STOP_LAST   = CNT_W'(STOP_CYC - 1);
    localparam logic [CNT_W-1:0] RESUME_LAST = CNT_W'(RESUME_CYC - 1);

    logic [NUM_SRC-1:0]    sync_req;
    logic [NUM_SRC-1:0]    act;
    logic                  any_act;
    logic [CAUSE_W-1:0]    winner;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic                  enable_d, pause_d;
    logic [CAUSE_W-1:0]    cause_d;
    logic                  cause_valid_d;
    logic [STOP_CNT_W-1:0] stop_count_d;
    logic [STOP_CNT_W-1:0] stop_count_inc;

    sync_2ff #(
        .W (NUM_SRC)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (stop_req),
        .q     (sync_req)
    );

    assign act     = sync_req & src_mask;
    assign any_act = |act;

    assign stop_count_inc = (stop_count == '1) ? stop_count
                                               : stop_count + STOP_CNT_W'(1);

`ifndef DRIVE_PAUSE_LATCH_EN
    logic unused_manual_clear;
    assign unused_manual_clear = manual_clear;
`endif

    // Lowest-index active source wins
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (act[i]) begin
                winner = CAUSE_W'(i);
            end
        end
    end

    // Next-state, timer and status; outputs decoded from the next state
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        cause_d       = cause;
        cause_valid_d = cause_valid;
        stop_count_d  = stop_count;

        case (state_q)
            ST_RUN: begin
                if (any_act) begin
                    state_d       = ST_STOP;
                    timer_d       = '0;
                    cause_d       = winner;
                    cause_valid_d = 1'b1;
                    stop_count_d  = stop_count_inc;
                end
            end
            ST_STOP: begin
                if (any_act) begin
                    timer_d = '0;
                end else if (timer_q == STOP_LAST) begin
`ifdef DRIVE_PAUSE_LATCH_EN
                    if (manual_clear) begin
                        state_d = ST_CREEP;
                        timer_d = '0;
                    end
`else
                    state_d = ST_CREEP;
                    timer_d = '0;
`endif
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            ST_CREEP: begin
                if (any_act) begin
                    state_d       = ST_STOP;
                    timer_d       = '0;
                    cause_d       = winner;
                    cause_valid_d = 1'b1;
                    stop_count_d  = stop_count_inc;
                end else if (timer_q == RESUME_LAST) begin
                    state_d = ST_RUN;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_STOP;
                timer_d = '0;
            end
        endcase

        enable_d = (state_d != ST_STOP);
        pause_d  = (state_d != ST_RUN);
    end

    // State, timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_STOP;
            timer_q     <= '0;
            enable      <= 1'b0;
            pause       <= 1'b1;
            cause       <= '0;
            cause_valid <= 1'b0;
            stop_count  <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            enable      <= enable_d;
            pause       <= pause_d;
            cause       <= cause_d;
            cause_valid <= cause_valid_d;
            stop_count  <= stop_count_d;
        end
    end

endmodule

// File: tb/tb_drive_pause_sequencer.sv
// Bench for drive_pause_sequencer: directed literal checks plus randomized
// stimulus compared every cycle against a phase/countdown reference model.
module tb_drive_pause_sequencer;

    localparam int unsigned NUM_SRC    = 4;
    localparam int unsigned STOP_CYC   = 8;
    localparam int unsigned RESUME_CYC = 4;
    localparam int unsigned CNT_W      = 28;
`ifdef DRIVE_PAUSE_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    localparam int PH_STOP  = 0;
    localparam int PH_CREEP = 1;
    localparam int PH_RUN   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] stop_req;
    logic [3:0] src_mask;
    logic       manual_clear;
    logic       enable;
    logic       pause;
    logic [1:0] cause;
    logic       cause_valid;
    logic [7:0] stop_count;

    int checks   = 0;
    int failures = 0;

    drive_pause_sequencer #(
        .NUM_SRC    (NUM_SRC),
        .STOP_CYC   (STOP_CYC),
        .RESUME_CYC (RESUME_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stop_req     (stop_req),
        .src_mask     (src_mask),
        .manual_clear (manual_clear),
        .enable       (enable),
        .pause        (pause),
        .cause        (cause),
        .cause_valid  (cause_valid),
        .stop_count   (stop_count)
    );

    always #5 clk = ~clk;

    // Reference: phase plus quiet cycles still required, requests seen via a
    // two-sample delay line.
    typedef struct {
        int         phase;
        int         remaining;
        logic [3:0] d1;
        logic [3:0] d2;
        logic [7:0] count;
        logic [1:0] cause;
        logic       valid;
    } model_t;

    model_t m;

    function automatic logic [1:0] lowest(input logic [3:0] v);
        logic [1:0] r;
        bit found;
        r = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (v[i] && !found) begin
                r = 2'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic model_t reset_model();
        model_t r;
        r.phase     = PH_STOP;
        r.remaining = int'(STOP_CYC);
        r.d1        = 4'h0;
        r.d2        = 4'h0;
        r.count     = 8'd0;
        r.cause     = 2'd0;
        r.valid     = 1'b0;
        return r;
    endfunction

    function automatic model_t step(input model_t s, input logic [3:0] req,
                                    input logic [3:0] mask, input logic mc);
        model_t r;
        logic [3:0] act;
        r = s;
        act = s.d2 & mask;
        r.d2 = s.d1;
        r.d1 = req;
        if (act != 4'h0) begin
            if (s.phase != PH_STOP) begin
                r.count = (s.count == 8'd255) ? s.count : s.count + 8'd1;
                r.cause = lowest(act);
                r.valid = 1'b1;
            end
            r.phase     = PH_STOP;
            r.remaining = int'(STOP_CYC);
        end else if (s.phase == PH_STOP) begin
            if (s.remaining > 1) begin
                r.remaining = s.remaining - 1;
            end else if (!LATCH || mc) begin
                r.phase     = PH_CREEP;
                r.remaining = int'(RESUME_CYC);
            end
        end else if (s.phase == PH_CREEP) begin
            if (s.remaining > 1) begin
                r.remaining = s.remaining - 1;
            end else begin
                r.phase = PH_RUN;
            end
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m <= reset_model();
        end else begin
            m <= step(m, stop_req, src_mask, manual_clear);
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("enable",      int'(enable),      int'(m.phase != PH_STOP));
            chk("pause",       int'(pause),       int'(m.phase != PH_RUN));
            chk("cause",       int'(cause),       int'(m.cause));
            chk("cause_valid", int'(cause_valid), int'(m.valid));
            chk("stop_count",  int'(stop_count),  int'(m.count));
        end
    end

    task automatic wait_run();
        int n;
        n = 0;
        while (pause !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_run_timeout", int'(pause), 0);
    endtask

    initial begin
        int hold;
        stop_req     = 4'h0;
        src_mask     = 4'hF;
        manual_clear = 1'b0;
        rst_n        = 1'b1;
        #1 rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_enable",      int'(enable),      0);
        chk("rst_pause",       int'(pause),       1);
        chk("rst_cause",       int'(cause),       0);
        chk("rst_cause_valid", int'(cause_valid), 0);
        chk("rst_stop_count",  int'(stop_count),  0);
        rst_n = 1'b1;

`ifndef DRIVE_PAUSE_LATCH_EN
        // Power-up: 8 stop cycles, 4 creep cycles, then run
        repeat (7) @(negedge clk);
        chk("pu_stop_c7_enable", int'(enable), 0);
        @(negedge clk);
        chk("pu_creep_enable", int'(enable), 1);
        chk("pu_creep_pause",  int'(pause),  1);
        repeat (3) @(negedge clk);
        chk("pu_creep_c3_pause", int'(pause), 1);
        @(negedge clk);
        chk("pu_run_pause",       int'(pause),       0);
        chk("pu_run_enable",      int'(enable),      1);
        chk("pu_run_cause_valid", int'(cause_valid), 0);

        // Single-cycle request on bit 2: enable drops 3 cycles later
        stop_req = 4'b0100;
        @(negedge clk);
        stop_req = 4'b0000;
        @(negedge clk);
        chk("lat_c2_enable", int'(enable), 1);
        @(negedge clk);
        chk("lat_c3_enable",      int'(enable),      0);
        chk("lat_cause",          int'(cause),       2);
        chk("lat_cause_valid",    int'(cause_valid), 1);
        chk("lat_stop_count",     int'(stop_count),  1);
        repeat (11) @(negedge clk);
        chk("lat_resume_c11_pause", int'(pause), 1);
        @(negedge clk);
        chk("lat_resume_c12_pause", int'(pause), 0);

        // Simultaneous bits 1 and 3
        stop_req = 4'b1010;
        @(negedge clk);
        stop_req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("simul_cause",      int'(cause),      1);
        chk("simul_stop_count", int'(stop_count), 2);
        wait_run();

        // Masked source has no effect
        src_mask = 4'b1110;
        stop_req = 4'b0001;
        repeat (6) @(negedge clk);
        chk("mask_enable",     int'(enable),     1);
        chk("mask_pause",      int'(pause),      0);
        chk("mask_stop_count", int'(stop_count), 2);
        stop_req = 4'b0000;
        repeat (3) @(negedge clk);
        src_mask = 4'hF;
`else
        // Latched stop: no auto-advance, clear ignored while request active
        repeat (12) @(negedge clk);
        chk("latch_hold_enable", int'(enable), 0);
        stop_req = 4'b0001;
        repeat (4) @(negedge clk);
        manual_clear = 1'b1;
        @(negedge clk);
        manual_clear = 1'b0;
        @(negedge clk);
        chk("latch_clear_ignored", int'(enable), 0);
        stop_req = 4'b0000;
        repeat (13) @(negedge clk);
        chk("latch_still_held", int'(enable), 0);
        manual_clear = 1'b1;
        @(negedge clk);
        manual_clear = 1'b0;
        chk("latch_creep_enable", int'(enable), 1);
        chk("latch_creep_pause",  int'(pause),  1);
`endif

        // Randomized traffic with one mid-run reset
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (i == 1500) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("mid_rst_stop_count", int'(stop_count), 0);
                chk("mid_rst_enable",     int'(enable),     0);
                rst_n = 1'b1;
            end
            if (hold == 0) begin
                if ($urandom_range(0, 9) < 6) begin
                    stop_req = 4'h0;
                    hold = int'($urandom_range(5, 40));
                end else begin
                    stop_req = 4'($urandom_range(1, 15));
                    hold = int'($urandom_range(1, 25));
                end
            end else begin
                hold--;
            end
            if ($urandom_range(0, 49) == 0) begin
                src_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            end
            manual_clear = ($urandom_range(0, 7) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
